// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V control unit: sequences fetch/decode/execute/memory/writeback
// and drives ALU control, datapath selects and write enables.
module multicycle_control_fsm #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       FlagZ,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ULASrcA,
  output logic [1:0] ULASrcB,
  output logic [2:0] ULAcontrol,
  output logic       IllegalOp,
  output logic [3:0] state
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  state_t     state_q;
  logic [1:0] alu_op;
  logic       op_known;

  assign op_known = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                    (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
  assign state    = state_q;

  // State register with next-state selection; reset returns to FETCH
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:    state_q <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_R:         state_q <= S_EXECUTER;
            OP_I:         state_q <= S_EXECUTEI;
            OP_BEQ:       state_q <= S_BEQ;
            OP_JAL:       state_q <= S_JAL;
            default:      state_q <= ILLEGAL_TRAP ? S_HALT : S_FETCH;
          endcase
        end
        S_MEMADR:   state_q <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  state_q <= S_MEMWB;
        S_MEMWB:    state_q <= S_FETCH;
        S_MEMWRITE: state_q <= S_FETCH;
        S_EXECUTER: state_q <= S_ALUWB;
        S_EXECUTEI: state_q <= S_ALUWB;
        S_ALUWB:    state_q <= S_FETCH;
        S_JAL:      state_q <= S_ALUWB;
        S_BEQ:      state_q <= S_FETCH;
        S_HALT:     state_q <= S_HALT;
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  // Moore decode of selects/enables; BEQ takes PCWrite from FlagZ, reset masks enables
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ULASrcA   = 2'b00;
    ULASrcB   = 2'b00;
    alu_op    = 2'b00;
    IllegalOp = 1'b0;
    if (rst) begin
      ResultSrc = 2'b10;
      ULASrcB   = 2'b10;
    end else begin
      case (state_q)
        S_FETCH: begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          ULASrcB   = 2'b10;
          ResultSrc = 2'b10;
        end
        S_DECODE: begin
          ULASrcA   = 2'b01;
          ULASrcB   = 2'b01;
          IllegalOp = ~op_known;
        end
        S_MEMADR: begin
          ULASrcA = 2'b10;
          ULASrcB = 2'b01;
        end
        S_MEMREAD: begin
          AdrSrc = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        S_MEMWRITE: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXECUTER: begin
          ULASrcA = 2'b10;
          alu_op  = 2'b10;
        end
        S_EXECUTEI: begin
          ULASrcA = 2'b10;
          ULASrcB = 2'b01;
          alu_op  = 2'b10;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
        end
        S_JAL: begin
          ULASrcA = 2'b01;
          ULASrcB = 2'b10;
          PCWrite = 1'b1;
        end
        S_BEQ: begin
          ULASrcA = 2'b10;
          alu_op  = 2'b01;
          PCWrite = FlagZ;
        end
        S_HALT: begin
          ResultSrc = 2'b10;
          ULASrcB   = 2'b10;
        end
        default: begin
        end
      endcase
    end
  end

  // ALU operation decode; subtract only for R-type with funct7[5] set
  always_comb begin
    ULAcontrol = 3'b000;
    case (alu_op)
      2'b01: ULAcontrol = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ULAcontrol = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
          3'b010:  ULAcontrol = 3'b101;
          3'b110:  ULAcontrol = 3'b011;
          3'b111:  ULAcontrol = 3'b010;
          default: ULAcontrol = 3'b000;
        endcase
      end
      default: ULAcontrol = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: both ILLEGAL_TRAP settings side by side.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       flag_z;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0] result_src, ula_src_a, ula_src_b;
  logic [2:0] ula_control;
  logic [3:0] state;

  logic       t_pc_write, t_adr_src, t_mem_write, t_ir_write, t_reg_write, t_illegal_op;
  logic [1:0] t_result_src, t_ula_src_a, t_ula_src_b;
  logic [2:0] t_ula_control;
  logic [3:0] t_state;

  int n_cmp;
  int n_err;

  logic [2:0] r_f3  [6] = '{3'd0, 3'd0, 3'd2, 3'd6, 3'd7, 3'd1};
  logic       r_f7  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [2:0] r_exp [6] = '{3'd1, 3'd0, 3'd5, 3'd3, 3'd2, 3'd0};
  logic [2:0] i_f3  [3] = '{3'd0, 3'd2, 3'd6};
  logic       i_f7  [3] = '{1'b1, 1'b0, 1'b1};
  logic [2:0] i_exp [3] = '{3'd0, 3'd5, 3'd3};

  multicycle_control_fsm #(.ILLEGAL_TRAP(1'b0)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .FlagZ(flag_z),
    .PCWrite(pc_write), .AdrSrc(adr_src), .MemWrite(mem_write), .IRWrite(ir_write),
    .RegWrite(reg_write), .ResultSrc(result_src), .ULASrcA(ula_src_a), .ULASrcB(ula_src_b),
    .ULAcontrol(ula_control), .IllegalOp(illegal_op), .state(state)
  );

  multicycle_control_fsm #(.ILLEGAL_TRAP(1'b1)) dut_trap (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .FlagZ(flag_z),
    .PCWrite(t_pc_write), .AdrSrc(t_adr_src), .MemWrite(t_mem_write), .IRWrite(t_ir_write),
    .RegWrite(t_reg_write), .ResultSrc(t_result_src), .ULASrcA(t_ula_src_a), .ULASrcB(t_ula_src_b),
    .ULAcontrol(t_ula_control), .IllegalOp(t_illegal_op), .state(t_state)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    op       = 7'b0000000;
    funct3   = 3'b000;
    funct7b5 = 1'b0;
    flag_z   = 1'b0;

    // Initial reset
    tick();
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_irwrite", 32'(ir_write), 32'd0);
    check("rst_pcwrite", 32'(pc_write), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_irwrite", 32'(ir_write), 32'd1);
    check("post_rst_pcwrite", 32'(pc_write), 32'd1);
    check("post_rst_srcb", 32'(ula_src_b), 32'd2);
    check("post_rst_ulactl", 32'(ula_control), 32'd0);

    // lw: 0,1,2,3,4,0
    op = 7'b0000011;
    tick();
    check("lw_decode", 32'(state), 32'd1);
    check("lw_decode_illegal", 32'(illegal_op), 32'd0);
    check("lw_decode_srca", 32'(ula_src_a), 32'd1);
    tick();
    check("lw_memadr", 32'(state), 32'd2);
    check("lw_memadr_srca", 32'(ula_src_a), 32'd2);
    check("lw_memadr_srcb", 32'(ula_src_b), 32'd1);
    tick();
    check("lw_memread", 32'(state), 32'd3);
    check("lw_memread_adrsrc", 32'(adr_src), 32'd1);
    check("lw_memread_memwrite", 32'(mem_write), 32'd0);
    tick();
    check("lw_memwb", 32'(state), 32'd4);
    check("lw_memwb_regwrite", 32'(reg_write), 32'd1);
    check("lw_memwb_resultsrc", 32'(result_src), 32'd1);
    check("lw_memwb_memwrite", 32'(mem_write), 32'd0);
    tick();
    check("lw_done", 32'(state), 32'd0);

    // Reset mid-instruction, held 2 cycles from MEMWB
    tick(); tick(); tick(); tick();
    check("mid_memwb", 32'(state), 32'd4);
    rst = 1'b1;
    #1;
    check("mid_rst_regwrite", 32'(reg_write), 32'd0);
    check("mid_rst_memwrite", 32'(mem_write), 32'd0);
    tick();
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_irwrite", 32'(ir_write), 32'd0);
    check("mid_rst_pcwrite", 32'(pc_write), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_rel_irwrite", 32'(ir_write), 32'd1);

    // sw: 0,1,2,5,0
    op = 7'b0100011;
    tick();
    tick();
    check("sw_memadr", 32'(state), 32'd2);
    tick();
    check("sw_memwrite", 32'(state), 32'd5);
    check("sw_memwrite_en", 32'(mem_write), 32'd1);
    check("sw_adrsrc", 32'(adr_src), 32'd1);
    check("sw_regwrite", 32'(reg_write), 32'd0);
    tick();
    check("sw_done", 32'(state), 32'd0);

    // R-type: 0,1,6,7,0 across funct3/funct7b5 patterns
    op = 7'b0110011;
    for (int i = 0; i < 6; i++) begin
      funct3   = r_f3[i];
      funct7b5 = r_f7[i];
      tick();
      tick();
      check("r_exec_state", 32'(state), 32'd6);
      check("r_exec_ulactl", 32'(ula_control), 32'(r_exp[i]));
      check("r_exec_srcb", 32'(ula_src_b), 32'd0);
      tick();
      check("r_aluwb_state", 32'(state), 32'd7);
      check("r_aluwb_regwrite", 32'(reg_write), 32'd1);
      tick();
      check("r_done", 32'(state), 32'd0);
    end

    // I-type: 0,1,8,7,0; funct7b5 must not turn addi into sub
    op = 7'b0010011;
    for (int i = 0; i < 3; i++) begin
      funct3   = i_f3[i];
      funct7b5 = i_f7[i];
      tick();
      tick();
      check("i_exec_state", 32'(state), 32'd8);
      check("i_exec_ulactl", 32'(ula_control), 32'(i_exp[i]));
      check("i_exec_srcb", 32'(ula_src_b), 32'd1);
      tick();
      check("i_aluwb_state", 32'(state), 32'd7);
      check("i_aluwb_regwrite", 32'(reg_write), 32'd1);
      tick();
      check("i_done", 32'(state), 32'd0);
    end

    // beq taken, then FlagZ dropped within the same cycle
    op       = 7'b1100011;
    funct3   = 3'b000;
    funct7b5 = 1'b0;
    flag_z   = 1'b1;
    tick();
    tick();
    check("beq_state", 32'(state), 32'd10);
    check("beq_z1_pcwrite", 32'(pc_write), 32'd1);
    check("beq_z1_ulactl", 32'(ula_control), 32'd1);
    flag_z = 1'b0;
    #1;
    check("beq_comb_pcwrite", 32'(pc_write), 32'd0);
    tick();
    check("beq_done", 32'(state), 32'd0);
    tick();
    tick();
    check("beq_z0_state", 32'(state), 32'd10);
    check("beq_z0_pcwrite", 32'(pc_write), 32'd0);
    check("beq_z0_ulactl", 32'(ula_control), 32'd1);
    tick();
    check("beq_z0_done", 32'(state), 32'd0);

    // jal: 0,1,9,7,0
    op = 7'b1101111;
    tick();
    tick();
    check("jal_state", 32'(state), 32'd9);
    check("jal_pcwrite", 32'(pc_write), 32'd1);
    check("jal_srca", 32'(ula_src_a), 32'd1);
    check("jal_srcb", 32'(ula_src_b), 32'd2);
    tick();
    check("jal_aluwb", 32'(state), 32'd7);
    check("jal_regwrite", 32'(reg_write), 32'd1);
    tick();
    check("jal_done", 32'(state), 32'd0);

    // Illegal opcode: pulse in DECODE, then FETCH or HALT
    op = 7'b1111111;
    tick();
    check("ill_decode", 32'(state), 32'd1);
    check("ill_pulse", 32'(illegal_op), 32'd1);
    check("ill_pulse_trap", 32'(t_illegal_op), 32'd1);
    tick();
    check("ill_next", 32'(state), 32'd0);
    check("ill_pulse_end", 32'(illegal_op), 32'd0);
    check("ill_trap_halt", 32'(t_state), 32'd11);
    check("ill_trap_srcb", 32'(t_ula_src_b), 32'd2);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halt_state", 32'(t_state), 32'd11);
      check("halt_enables", 32'({t_pc_write, t_mem_write, t_ir_write, t_reg_write, t_illegal_op}), 32'd0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    op  = 7'b0000011;
    #1;
    check("halt_rst_state", 32'(t_state), 32'd0);
    check("halt_rst_irwrite", 32'(t_ir_write), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
